gs_guncelleme_zamanlayici: RTL and testbench
============================================

// Module: gs_guncelleme_zamanlayici
// PURPOSE
// Arbitrates and sequences gshare predictor update requests from the decode (COZ) and execute (YURUT) stages.
// Buffers accepted requests in a small FIFO and issues at most one update per cycle on the predictor's update port.
// The output fields map directly onto the predictor's update inputs:
//   gs_guncelle_o        -> coz_gs_guncelle_i
//   gs_dallanma_olan_ps_o -> coz_dallanma_olan_ps_i
//   gs_dallanilan_ps_o   -> coz_dallanilan_ps_i
//   gs_dallanma_oldu_o   -> coz_dallanma_oldu_i
// Sits between the pipeline branch-resolution points and gshare.
// PARAMETERS
// KUYRUK_DERINLIGI  4  FIFO entries; power of two, >=2
// ACLIK_SINIRI      3  consecutive cycles a COZ request may lose arbitration before it is forced to win; >=1
// PORTS
// clk_i                  in   1   clock
// rstn_i                 in   1   reset, synchronous, active-low
// coz_gecerli_i          in   1   decode-stage update request valid
// coz_hazir_o            out  1   decode request accepted this cycle when gecerli&hazir
// coz_ps_i               in   32  branch PC (decode)
// coz_hedef_ps_i         in   32  branch target PC (decode)
// coz_dallanma_oldu_i    in   1   taken (decode)
// yurut_gecerli_i        in   1   execute-stage update request valid
// yurut_hazir_o          out  1   execute request accepted when gecerli&hazir
// yurut_ps_i             in   32  branch PC (execute)
// yurut_hedef_ps_i       in   32  branch target PC (execute)
// yurut_dallanma_oldu_i  in   1   taken (execute)
// temizle_i              in   1   pipeline flush: discard all queued entries
// durdur_i               in   1   hold issue to predictor this cycle
// gs_guncelle_o          out  1   update strobe to predictor
// gs_dallanma_olan_ps_o  out  32  PC to predictor
// gs_dallanilan_ps_o     out  32  target to predictor
// gs_dallanma_oldu_o     out  1   taken to predictor
// kuyruk_dolu_o          out  1   FIFO full
// BEHAVIOUR
// - Reset:
//   - FIFO empty; pointers, count and starvation counter cleared.
//   - All outputs 0, except both hazir_o, which are 1 once the FIFO is empty.
// - One enqueue per cycle:
//   - YURUT wins by default.
//   - COZ wins if only COZ is valid, or if the starvation counter equals ACLIK_SINIRI.
//   - Only the winner sees hazir_o=1; the loser sees hazir_o=0.
// - Starvation counter:
//   - Increments (saturating at ACLIK_SINIRI) each cycle COZ is valid but not granted.
//   - Clears on a COZ grant or when coz_gecerli_i=0.
// - hazir_o is forced 0 on both ports when:
//   - the FIFO is full and no dequeue happens this cycle (no combinational full-bypass beyond that), or
//   - temizle_i=1.
// - Dequeue:
//   - Occurs when FIFO non-empty and durdur_i=0.
//   - The head entry drives the gs_* outputs from registers the cycle after dequeue.
//   - gs_guncelle_o is a 1-cycle pulse per entry.
//   - gs_* data fields are held at their last values when no update is issued.
// - Latency: a request accepted in cycle N into an empty FIFO with durdur_i=0 pulses gs_guncelle_o in cycle N+2.
//   - Cycle N+1: write → head.
//   - Cycle N+2: registered output.
// - Simultaneous enqueue and dequeue when full: allowed (hazir_o=1); the count is unchanged.
// - Pointers wrap modulo KUYRUK_DERINLIGI; count is clog2(D)+1 bits and distinguishes full from empty.
// - temizle_i:
//   - Empties the FIFO at the next edge and clears the starvation counter.
//   - An output pulse already registered in the same cycle still completes.
//   - No request is accepted in a flush cycle.
// - durdur_i=1 freezes dequeue only; enqueue continues until full.
// - Order: entries are issued strictly in acceptance order.
// - Reset mid-operation: all queued entries are lost and no gs_guncelle_o is asserted after reset.
// CONFIGURATION
// - GS_SAYAC_EN defined: adds three 32-bit wrapping outputs, all reset to 0:
//   - sayac_guncelleme_o: gs_guncelle_o pulses
//   - sayac_atilan_o: entries discarded by temizle_i
//   - sayac_dolu_o: cycles with kuyruk_dolu_o=1
// - GS_SAYAC_EN undefined: these ports and their logic are absent; behaviour is otherwise identical.
// TESTING
// 1. Reset, then COZ request PC=0x100, target=0x180, taken=1 with FIFO empty:
//    -> coz_hazir_o=1, and 2 cycles later gs_guncelle_o=1 with 0x100/0x180/1.
// 2. COZ and YURUT valid every cycle, durdur_i=1, ACLIK_SINIRI=3:
//    -> YURUT is granted for 3 cycles, COZ is granted on the 4th;
//    -> kuyruk_dolu_o=1 after 4 accepts, and both hazir_o=0.
// 3. FIFO full with 4 entries, then durdur_i drops while YURUT is valid:
//    -> enqueue and dequeue in the same cycle, count stays 4;
//    -> outputs are issued in order over 4 consecutive cycles.
// 4. Three entries queued, temizle_i=1 for 1 cycle with COZ valid:
//    -> coz_hazir_o=0, FIFO empty next cycle, no further gs_guncelle_o;
//    -> sayac_atilan_o=3 with GS_SAYAC_EN.
// 5. Write and read 9 entries through D=4 with random durdur_i:
//    -> all 9 are issued in order, verifying pointer wrap.
// 6. rstn_i=0 mid-stream with 2 queued entries:
//    -> the next cycle has gs_guncelle_o=0, both hazir_o=1, and counters=0.

Source files
------------

// File: rtl/gs_guncelleme_zamanlayici.sv
// gs_guncelleme_zamanlayici
//   Sequences gshare update requests from the decode (COZ) and execute (YURUT)
//   stages. Up to one request per cycle is accepted into a small FIFO, and at
//   most one update per cycle is issued to the predictor's update port from
//   registered outputs.
//
// Ports
//   clk_i, rstn_i            clock, synchronous active-low reset
//   coz_*                    decode-stage request (valid/ready, PC, target, taken)
//   yurut_*                  execute-stage request (valid/ready, PC, target, taken)
//   temizle_i                flush: drop every queued entry, accept nothing this cycle
//   durdur_i                 hold issue to the predictor this cycle
//   gs_*                     registered update strobe and payload to the predictor
//   kuyruk_dolu_o            FIFO full (registered)
//
// Build option
//   GS_SAYAC_EN              adds sayac_guncelleme_o, sayac_atilan_o and
//                            sayac_dolu_o event counters (32-bit, wrapping).
//
// Arbitration: YURUT wins by default; COZ wins when it is the only requester or
// when it has already lost ACLIK_SINIRI consecutive cycles. coz_hazir_o and
// yurut_hazir_o are combinational, since they depend on this cycle's requests.

module gs_guncelleme_zamanlayici #(
  parameter int unsigned KUYRUK_DERINLIGI = 4,
  parameter int unsigned ACLIK_SINIRI     = 3
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        coz_gecerli_i,
  output logic        coz_hazir_o,
  input  logic [31:0] coz_ps_i,
  input  logic [31:0] coz_hedef_ps_i,
  input  logic        coz_dallanma_oldu_i,
  input  logic        yurut_gecerli_i,
  output logic        yurut_hazir_o,
  input  logic [31:0] yurut_ps_i,
  input  logic [31:0] yurut_hedef_ps_i,
  input  logic        yurut_dallanma_oldu_i,
  input  logic        temizle_i,
  input  logic        durdur_i,
  output logic        gs_guncelle_o,
  output logic [31:0] gs_dallanma_olan_ps_o,
  output logic [31:0] gs_dallanilan_ps_o,
  output logic        gs_dallanma_oldu_o,
  output logic        kuyruk_dolu_o
`ifdef GS_SAYAC_EN
  ,
  output logic [31:0] sayac_guncelleme_o,
  output logic [31:0] sayac_atilan_o,
  output logic [31:0] sayac_dolu_o
`endif
);

  localparam int unsigned PS_W    = 32;
  localparam int unsigned ADR_W   = (KUYRUK_DERINLIGI > 1) ? $clog2(KUYRUK_DERINLIGI) : 1;
  localparam int unsigned SAY_W   = ADR_W + 1;
  localparam int unsigned ACLIK_W = $clog2(ACLIK_SINIRI + 1);

  localparam logic [SAY_W-1:0]   DOLU_SAYI = SAY_W'(KUYRUK_DERINLIGI);
  localparam logic [ACLIK_W-1:0] ACLIK_UST = ACLIK_W'(ACLIK_SINIRI);

  typedef struct packed {
    logic [PS_W-1:0] ps;
    logic [PS_W-1:0] hedef;
    logic            oldu;
  } kayit_t;

  // FIFO storage and bookkeeping
  kayit_t              kuyruk_q [KUYRUK_DERINLIGI];
  logic [ADR_W-1:0]    yaz_ptr_q, yaz_ptr_d;
  logic [ADR_W-1:0]    oku_ptr_q, oku_ptr_d;
  logic [SAY_W-1:0]    sayi_q, sayi_d;
  logic                dolu_q, dolu_d;
  logic [ACLIK_W-1:0]  aclik_q, aclik_d;

  // Per-cycle decisions
  logic   bos_c;
  logic   cek_c;
  logic   kabul_c;
  logic   coz_oncelik_c;
  logic   coz_izin_c;
  logic   yurut_izin_c;
  logic   yaz_c;
  kayit_t yaz_veri_c;
  kayit_t bas_c;

  // Arbitration, ready generation and dequeue decision
  always_comb begin
    bos_c         = (sayi_q == '0);
    // Flush suppresses dequeue so that queued entries are dropped, not issued.
    cek_c         = !bos_c && !durdur_i && !temizle_i;
    // Full FIFO accepts only when a slot frees in the same cycle.
    kabul_c       = rstn_i && !temizle_i && (!dolu_q || cek_c);
    coz_oncelik_c = (aclik_q == ACLIK_UST) || !yurut_gecerli_i;

    coz_hazir_o   = kabul_c && coz_oncelik_c;
    yurut_hazir_o = kabul_c && !(coz_gecerli_i && coz_oncelik_c);

    coz_izin_c    = coz_gecerli_i && coz_hazir_o;
    yurut_izin_c  = yurut_gecerli_i && yurut_hazir_o && !coz_izin_c;
    yaz_c         = coz_izin_c || yurut_izin_c;

    if (coz_izin_c) begin
      yaz_veri_c = '{ps: coz_ps_i, hedef: coz_hedef_ps_i, oldu: coz_dallanma_oldu_i};
    end else begin
      yaz_veri_c = '{ps: yurut_ps_i, hedef: yurut_hedef_ps_i, oldu: yurut_dallanma_oldu_i};
    end

    bas_c = kuyruk_q[oku_ptr_q];
  end

  // Next-state for pointers, occupancy and starvation counter
  always_comb begin
    yaz_ptr_d = yaz_ptr_q;
    oku_ptr_d = oku_ptr_q;
    sayi_d    = sayi_q;
    aclik_d   = aclik_q;

    if (temizle_i) begin
      yaz_ptr_d = '0;
      oku_ptr_d = '0;
      sayi_d    = '0;
    end else begin
      if (yaz_c) begin
        yaz_ptr_d = yaz_ptr_q + ADR_W'(1);
      end
      if (cek_c) begin
        oku_ptr_d = oku_ptr_q + ADR_W'(1);
      end
      case ({yaz_c, cek_c})
        2'b10:   sayi_d = sayi_q + SAY_W'(1);
        2'b01:   sayi_d = sayi_q - SAY_W'(1);
        default: sayi_d = sayi_q;
      endcase
    end

    dolu_d = (sayi_d == DOLU_SAYI);

    // COZ losing while valid ages it toward forced priority.
    if (temizle_i || !coz_gecerli_i || coz_izin_c) begin
      aclik_d = '0;
    end else if (aclik_q != ACLIK_UST) begin
      aclik_d = aclik_q + ACLIK_W'(1);
    end
  end

  // State registers
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      yaz_ptr_q <= '0;
      oku_ptr_q <= '0;
      sayi_q    <= '0;
      dolu_q    <= 1'b0;
      aclik_q   <= '0;
    end else begin
      yaz_ptr_q <= yaz_ptr_d;
      oku_ptr_q <= oku_ptr_d;
      sayi_q    <= sayi_d;
      dolu_q    <= dolu_d;
      aclik_q   <= aclik_d;
    end
  end

  // Entry storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk_i) begin
    if (yaz_c) begin
      kuyruk_q[yaz_ptr_q] <= yaz_veri_c;
    end
  end

  // Predictor update port; payload holds its last value between updates
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      gs_guncelle_o         <= 1'b0;
      gs_dallanma_olan_ps_o <= '0;
      gs_dallanilan_ps_o    <= '0;
      gs_dallanma_oldu_o    <= 1'b0;
    end else begin
      gs_guncelle_o <= cek_c;
      if (cek_c) begin
        gs_dallanma_olan_ps_o <= bas_c.ps;
        gs_dallanilan_ps_o    <= bas_c.hedef;
        gs_dallanma_oldu_o    <= bas_c.oldu;
      end
    end
  end

  assign kuyruk_dolu_o = dolu_q;

`ifdef GS_SAYAC_EN
  // Event counters: issued updates, flushed entries, full cycles
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      sayac_guncelleme_o <= '0;
      sayac_atilan_o     <= '0;
      sayac_dolu_o       <= '0;
    end else begin
      if (cek_c) begin
        sayac_guncelleme_o <= sayac_guncelleme_o + 32'd1;
      end
      if (temizle_i) begin
        sayac_atilan_o <= sayac_atilan_o + 32'(sayi_q);
      end
      if (dolu_q) begin
        sayac_dolu_o <= sayac_dolu_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_gs_guncelleme_zamanlayici.sv
// Testbench for gs_guncelleme_zamanlayici: a hand-written vector table for
// the basic flows, hand sequences for flush / wrap / reset, and randomized
// traffic, all checked against a queue-based reference model.

module tb_gs_guncelleme_zamanlayici;

  localparam int unsigned D  = 4;
  localparam int unsigned AS = 3;

  logic        clk = 1'b0;
  logic        rstn_i;
  logic        coz_gecerli_i, coz_hazir_o, coz_dallanma_oldu_i;
  logic [31:0] coz_ps_i, coz_hedef_ps_i;
  logic        yurut_gecerli_i, yurut_hazir_o, yurut_dallanma_oldu_i;
  logic [31:0] yurut_ps_i, yurut_hedef_ps_i;
  logic        temizle_i, durdur_i;
  logic        gs_guncelle_o, gs_dallanma_oldu_o, kuyruk_dolu_o;
  logic [31:0] gs_dallanma_olan_ps_o, gs_dallanilan_ps_o;
`ifdef GS_SAYAC_EN
  logic [31:0] sayac_guncelleme_o, sayac_atilan_o, sayac_dolu_o;
`endif

  always #5 clk = ~clk;

  gs_guncelleme_zamanlayici #(
    .KUYRUK_DERINLIGI(D),
    .ACLIK_SINIRI    (AS)
  ) dut (
    .clk_i                 (clk),
    .rstn_i                (rstn_i),
    .coz_gecerli_i         (coz_gecerli_i),
    .coz_hazir_o           (coz_hazir_o),
    .coz_ps_i              (coz_ps_i),
    .coz_hedef_ps_i        (coz_hedef_ps_i),
    .coz_dallanma_oldu_i   (coz_dallanma_oldu_i),
    .yurut_gecerli_i       (yurut_gecerli_i),
    .yurut_hazir_o         (yurut_hazir_o),
    .yurut_ps_i            (yurut_ps_i),
    .yurut_hedef_ps_i      (yurut_hedef_ps_i),
    .yurut_dallanma_oldu_i (yurut_dallanma_oldu_i),
    .temizle_i             (temizle_i),
    .durdur_i              (durdur_i),
    .gs_guncelle_o         (gs_guncelle_o),
    .gs_dallanma_olan_ps_o (gs_dallanma_olan_ps_o),
    .gs_dallanilan_ps_o    (gs_dallanilan_ps_o),
    .gs_dallanma_oldu_o    (gs_dallanma_oldu_o),
    .kuyruk_dolu_o         (kuyruk_dolu_o)
`ifdef GS_SAYAC_EN
    ,
    .sayac_guncelleme_o    (sayac_guncelleme_o),
    .sayac_atilan_o        (sayac_atilan_o),
    .sayac_dolu_o          (sayac_dolu_o)
`endif
  );

  typedef struct {
    bit          rstn, coz_v, yurut_v, temizle, durdur;
    logic [31:0] coz_ps, coz_hedef, yurut_ps, yurut_hedef;
    bit          coz_oldu, yurut_oldu;
  } in_t;

  typedef struct {
    in_t         g;
    bit          chk;
    bit          e_ch, e_yh, e_gun, e_dolu;
    logic [31:0] e_ps;
  } vek_t;

  typedef struct packed {
    logic [31:0] ps;
    logic [31:0] hedef;
    logic        oldu;
  } kayit_t;

  int n_cmp = 0;
  int n_err = 0;
  int n_puls = 0;

  // Reference model state
  kayit_t      mq[$];
  int unsigned aclik = 0;
  bit          model_gecerli = 1'b0;
  bit          m_gun = 1'b0;
  logic [31:0] m_ps = '0, m_hedef = '0;
  bit          m_oldu = 1'b0;
  int unsigned m_say_gun = 0, m_say_atilan = 0, m_say_dolu = 0;
  bit          son_kabul = 1'b0;

  function automatic void kontrol(string ad, logic [31:0] gercek, logic [31:0] beklenen);
    n_cmp++;
    if (gercek !== beklenen) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", ad, gercek, beklenen, $time);
    end
  endfunction

  function automatic in_t mk(bit rstn, bit cv, bit yv, bit tem, bit dur,
                             logic [31:0] cps, logic [31:0] yps);
    in_t g;
    g.rstn = rstn; g.coz_v = cv; g.yurut_v = yv; g.temizle = tem; g.durdur = dur;
    g.coz_ps = cps;   g.coz_hedef = cps + 32'h80;     g.coz_oldu = ~cps[0];
    g.yurut_ps = yps; g.yurut_hedef = yps + 32'h1000; g.yurut_oldu = yps[0];
    return g;
  endfunction

  function automatic vek_t tv(in_t g, bit ch, bit yh, bit gun, bit dolu, logic [31:0] ps);
    vek_t v;
    v.g = g; v.chk = 1'b1; v.e_ch = ch; v.e_yh = yh; v.e_gun = gun; v.e_dolu = dolu; v.e_ps = ps;
    return v;
  endfunction

  function automatic vek_t yal(in_t g);
    vek_t v;
    v.g = g; v.chk = 1'b0; v.e_ch = 1'b0; v.e_yh = 1'b0; v.e_gun = 1'b0; v.e_dolu = 1'b0; v.e_ps = '0;
    return v;
  endfunction

  // One clock cycle: drive, check at the falling edge, advance the model.
  task automatic adim(input vek_t v);
    in_t    g;
    bit     bos, dolu, cek, acik, coz_once, e_ch, e_yh, coz_al, yur_al;
    kayit_t e;
    g = v.g;
    rstn_i = g.rstn; coz_gecerli_i = g.coz_v; yurut_gecerli_i = g.yurut_v;
    temizle_i = g.temizle; durdur_i = g.durdur;
    coz_ps_i = g.coz_ps; coz_hedef_ps_i = g.coz_hedef; coz_dallanma_oldu_i = g.coz_oldu;
    yurut_ps_i = g.yurut_ps; yurut_hedef_ps_i = g.yurut_hedef; yurut_dallanma_oldu_i = g.yurut_oldu;
    @(negedge clk);

    bos      = (mq.size() == 0);
    dolu     = (mq.size() == D);
    cek      = !bos && !g.durdur && !g.temizle;
    acik     = !g.temizle && (!dolu || cek);
    coz_once = (aclik == AS) || !g.yurut_v;
    e_ch     = acik && coz_once;
    e_yh     = acik && !(g.coz_v && coz_once);

    if (model_gecerli) begin
      if (g.rstn) begin
        kontrol("coz_hazir", 32'(coz_hazir_o), 32'(e_ch));
        kontrol("yurut_hazir", 32'(yurut_hazir_o), 32'(e_yh));
      end
      kontrol("gs_guncelle", 32'(gs_guncelle_o), 32'(m_gun));
      kontrol("gs_ps", gs_dallanma_olan_ps_o, m_ps);
      kontrol("gs_hedef", gs_dallanilan_ps_o, m_hedef);
      kontrol("gs_oldu", 32'(gs_dallanma_oldu_o), 32'(m_oldu));
      kontrol("kuyruk_dolu", 32'(kuyruk_dolu_o), 32'(dolu));
`ifdef GS_SAYAC_EN
      kontrol("sayac_guncelleme", sayac_guncelleme_o, m_say_gun);
      kontrol("sayac_atilan", sayac_atilan_o, m_say_atilan);
      kontrol("sayac_dolu", sayac_dolu_o, m_say_dolu);
`endif
    end
    if (v.chk) begin
      kontrol("tbl_coz_hazir", 32'(coz_hazir_o), 32'(v.e_ch));
      kontrol("tbl_yurut_hazir", 32'(yurut_hazir_o), 32'(v.e_yh));
      kontrol("tbl_gs_guncelle", 32'(gs_guncelle_o), 32'(v.e_gun));
      kontrol("tbl_kuyruk_dolu", 32'(kuyruk_dolu_o), 32'(v.e_dolu));
      kontrol("tbl_gs_ps", gs_dallanma_olan_ps_o, v.e_ps);
    end
    if (gs_guncelle_o === 1'b1) n_puls++;

    coz_al    = g.rstn && g.coz_v && e_ch;
    yur_al    = g.rstn && !coz_al && g.yurut_v && e_yh;
    son_kabul = coz_al || yur_al;
    if (!g.rstn) begin
      mq.delete();
      aclik = 0; m_gun = 1'b0; m_ps = '0; m_hedef = '0; m_oldu = 1'b0;
      m_say_gun = 0; m_say_atilan = 0; m_say_dolu = 0;
      model_gecerli = 1'b1;
    end else begin
      if (dolu) m_say_dolu++;
      if (cek) begin
        e = mq.pop_front();
        m_gun = 1'b1; m_ps = e.ps; m_hedef = e.hedef; m_oldu = e.oldu;
        m_say_gun++;
      end else begin
        m_gun = 1'b0;
      end
      if (g.temizle) begin
        m_say_atilan += mq.size();
        mq.delete();
      end
      if (coz_al) begin
        e.ps = g.coz_ps; e.hedef = g.coz_hedef; e.oldu = g.coz_oldu;
        mq.push_back(e);
      end else if (yur_al) begin
        e.ps = g.yurut_ps; e.hedef = g.yurut_hedef; e.oldu = g.yurut_oldu;
        mq.push_back(e);
      end
      if (g.temizle || !g.coz_v || coz_al) aclik = 0;
      else if (aclik < AS) aclik++;
    end
    @(posedge clk);
    #1;
  endtask

  vek_t tablo[$];
  in_t  bos_g;

  initial begin
    int acc;
    int p0;
    rstn_i = 1'b0; coz_gecerli_i = 1'b0; yurut_gecerli_i = 1'b0;
    temizle_i = 1'b0; durdur_i = 1'b0;
    coz_ps_i = '0; coz_hedef_ps_i = '0; coz_dallanma_oldu_i = 1'b0;
    yurut_ps_i = '0; yurut_hedef_ps_i = '0; yurut_dallanma_oldu_i = 1'b0;
    bos_g = mk(1, 0, 0, 0, 0, 32'h0, 32'h0);

    // Reset value table, single COZ request, starvation, full bypass, ordered drain
    tablo.push_back(tv(mk(1, 1, 0, 0, 0, 32'h100, 32'h0),   1, 0, 0, 0, 32'h0));
    tablo.push_back(tv(bos_g,                                1, 1, 0, 0, 32'h0));
    tablo.push_back(tv(bos_g,                                1, 1, 1, 0, 32'h100));
    tablo.push_back(tv(bos_g,                                1, 1, 0, 0, 32'h100));
    tablo.push_back(tv(mk(1, 1, 1, 0, 1, 32'h200, 32'h300), 0, 1, 0, 0, 32'h100));
    tablo.push_back(tv(mk(1, 1, 1, 0, 1, 32'h200, 32'h301), 0, 1, 0, 0, 32'h100));
    tablo.push_back(tv(mk(1, 1, 1, 0, 1, 32'h200, 32'h302), 0, 1, 0, 0, 32'h100));
    tablo.push_back(tv(mk(1, 1, 1, 0, 1, 32'h200, 32'h303), 1, 0, 0, 0, 32'h100));
    tablo.push_back(tv(mk(1, 1, 1, 0, 1, 32'h201, 32'h304), 0, 0, 0, 1, 32'h100));
    tablo.push_back(tv(mk(1, 0, 1, 0, 0, 32'h0,   32'h400), 0, 1, 0, 1, 32'h100));
    tablo.push_back(tv(mk(1, 0, 1, 0, 0, 32'h0,   32'h401), 0, 1, 1, 1, 32'h300));
    tablo.push_back(tv(bos_g,                                1, 1, 1, 1, 32'h301));
    tablo.push_back(tv(bos_g,                                1, 1, 1, 0, 32'h302));
    tablo.push_back(tv(bos_g,                                1, 1, 1, 0, 32'h200));
    tablo.push_back(tv(bos_g,                                1, 1, 1, 0, 32'h400));
    tablo.push_back(tv(bos_g,                                1, 1, 1, 0, 32'h401));
    tablo.push_back(tv(bos_g,                                1, 1, 0, 0, 32'h401));

    @(posedge clk);
    #1;
    adim(yal(mk(0, 0, 0, 0, 0, 32'h0, 32'h0)));
    adim(yal(mk(0, 0, 0, 0, 0, 32'h0, 32'h0)));
    for (int i = 0; i < tablo.size(); i++) adim(tablo[i]);

    // Flush with three queued entries and a COZ request present
    for (int i = 0; i < 3; i++) adim(yal(mk(1, 0, 1, 0, 1, 32'h0, 32'h500 + 32'(i))));
    adim(tv(mk(1, 1, 0, 1, 0, 32'h510, 32'h0), 0, 0, 0, 0, 32'h401));
    for (int i = 0; i < 4; i++) adim(tv(bos_g, 1, 1, 0, 0, 32'h401));
`ifdef GS_SAYAC_EN
    kontrol("flush_atilan", sayac_atilan_o, 32'd3);
`endif

    // Nine entries through a four-deep FIFO with random stalls
    acc = 0;
    p0  = n_puls;
    for (int c = 0; c < 300 && acc < 9; c++) begin
      adim(yal(mk(1, 0, 1, 0, 1'($urandom_range(0, 1)), 32'h0, 32'h600 + 32'(acc))));
      if (son_kabul) acc++;
    end
    for (int i = 0; i < 8; i++) adim(yal(bos_g));
    kontrol("wrap_kabul", 32'(acc), 32'd9);
    kontrol("wrap_puls", 32'(n_puls - p0), 32'd9);

    // Reset with two entries queued and dequeue otherwise enabled
    adim(yal(mk(1, 0, 1, 0, 1, 32'h0, 32'h700)));
    adim(yal(mk(1, 0, 1, 0, 1, 32'h0, 32'h701)));
    adim(yal(mk(0, 0, 0, 0, 0, 32'h0, 32'h0)));
    adim(tv(bos_g, 1, 1, 0, 0, 32'h0));
    for (int i = 0; i < 3; i++) adim(tv(bos_g, 1, 1, 0, 0, 32'h0));

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      in_t g;
      g.rstn        = ($urandom_range(0, 99) != 0);
      g.coz_v       = 1'($urandom_range(0, 1));
      g.yurut_v     = 1'($urandom_range(0, 1));
      g.temizle     = ($urandom_range(0, 19) == 0);
      g.durdur      = ($urandom_range(0, 2) == 0);
      g.coz_ps      = $urandom;
      g.coz_hedef   = $urandom;
      g.coz_oldu    = 1'($urandom_range(0, 1));
      g.yurut_ps    = $urandom;
      g.yurut_hedef = $urandom;
      g.yurut_oldu  = 1'($urandom_range(0, 1));
      adim(yal(g));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
